// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic array control slice.
// Holds the load-sequencer state encoding, the load-lock ownership codes used
// by the array controller, and the helper that derives the last issue tick.
package sys_array_pkg;

  // Load sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Load lock ownership as tracked by the array controller.
  localparam logic [1:0] LOCK_FREE = 2'd0;
  localparam logic [1:0] LOCK_ZERO = 2'd1;
  localparam logic [1:0] LOCK_ONE  = 2'd2;

  // Last tick value of the ISSUE phase: the final column starts MESHUNITS-1
  // cycles late and then needs N reads, so the last read is at N+MESHUNITS-2.
  function automatic int t_last_of(input int meshunits, input int tileunits);
    return meshunits * tileunits + meshunits - 2;
  endfunction

endpackage

// File: rtl/skew_addr_gen.sv
// Per-column skewed B read address generator.
// Ports: tick/base/issuing from the sequencer; addr/en are the column's read
// address and enable, decoded combinationally from the sequencer's registers.
module skew_addr_gen #(
  parameter int COL       = 0,
  parameter int N         = 4,
  parameter int TILEUNITS = 1,
  parameter int ADDRWIDTH = 16,
  parameter int TICKW     = 3
) (
  input  logic [TICKW-1:0]     tick,
  input  logic [ADDRWIDTH-1:0] base,
  input  logic                 issuing,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 en
);

  // Row index for this column; one extra bit catches tick < COL as a borrow.
  logic [TICKW:0]     row;
  logic               active;
  logic [ADDRWIDTH-1:0] row_addr;

  always_comb begin
    row      = {1'b0, tick} - (TICKW+1)'(COL);
    active   = issuing && !row[TICKW] && (row < (TICKW+1)'(N));
    row_addr = ADDRWIDTH'(row[TICKW-1:0]);
    en       = active;
    addr     = '0;
    if (active) begin
      // Arithmetic stays in ADDRWIDTH bits so the address wraps modulo 2^ADDRWIDTH.
      addr = base + row_addr * ADDRWIDTH'(N) + ADDRWIDTH'(COL * TILEUNITS);
    end
  end

endmodule

// File: rtl/b_preload_sequencer.sv
// Sequences the preload of one B weight tile into the systolic mesh.
// Ports: start/b_base_addr/thread_id request a load (accepted when ready);
// ready/busy/done report progress; B_col_read_* drive B memory; b_valid and
// propagate drive the mesh B side. All outputs come from registered state.
module b_preload_sequencer #(
  parameter int ADDRWIDTH = 16,
  parameter int MESHUNITS = 4,
  parameter int TILEUNITS = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDRWIDTH-1:0]                b_base_addr,
  input  logic                                thread_id,
  output logic                                ready,
  output logic                                busy,
  output logic                                done,
  output logic                                load_owner,
  output logic [MESHUNITS-1:0][ADDRWIDTH-1:0] B_col_read_addrs,
  output logic [MESHUNITS-1:0]                B_col_read_en,
  output logic [MESHUNITS-1:0][TILEUNITS-1:0] b_valid,
  output logic [MESHUNITS-1:0][TILEUNITS-1:0] propagate
);
  import sys_array_pkg::*;

  localparam int N      = MESHUNITS * TILEUNITS;
  localparam int T_LAST = t_last_of(MESHUNITS, TILEUNITS);
  localparam int TICKW  = (T_LAST > 0) ? $clog2(T_LAST + 1) : 1;

  seq_state_t            state_q, state_d;
  logic [TICKW-1:0]      tick_q, tick_d;
  logic [ADDRWIDTH-1:0]  base_q, base_d;
  logic                  owner_q, owner_d;
  logic                  prop_q, prop_d;
  logic [MESHUNITS-1:0]  b_valid_q, b_valid_d;
  logic [MESHUNITS-1:0]  col_en;
  logic                  issuing;

  assign issuing = (state_q == ST_ISSUE);

  for (genvar c = 0; c < MESHUNITS; c++) begin : g_col
    skew_addr_gen #(
      .COL       (c),
      .N         (N),
      .TILEUNITS (TILEUNITS),
      .ADDRWIDTH (ADDRWIDTH),
      .TICKW     (TICKW)
    ) u_skew_addr_gen (
      .tick    (tick_q),
      .base    (base_q),
      .issuing (issuing),
      .addr    (B_col_read_addrs[c]),
      .en      (col_en[c])
    );
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    base_d    = base_q;
    owner_d   = owner_q;
    prop_d    = prop_q;
    // Memory read data lands one cycle after the enable.
    b_valid_d = col_en;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          tick_d  = '0;
          base_d  = b_base_addr;
          owner_d = thread_id;
          // Alternate weight buffers so the mesh can compute on the previous tile.
          prop_d  = ~prop_q;
        end
      end
      ST_ISSUE: begin
        if (tick_q == TICKW'(T_LAST)) begin
          state_d = ST_DRAIN;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      base_q    <= '0;
      owner_q   <= 1'b0;
      prop_q    <= 1'b0;
      b_valid_q <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      base_q    <= base_d;
      owner_q   <= owner_d;
      prop_q    <= prop_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign load_owner    = owner_q;
  assign B_col_read_en = col_en;

  always_comb begin
    for (int i = 0; i < MESHUNITS; i++) begin
      for (int j = 0; j < TILEUNITS; j++) begin
        b_valid[i][j]   = b_valid_q[i];
        propagate[i][j] = prop_q;
      end
    end
  end

endmodule

// File: tb/tb_b_preload_sequencer.sv
module tb_b_preload_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT 0: MESHUNITS=4, TILEUNITS=1
  logic              start0 = 1'b0;
  logic [15:0]       base0 = '0;
  logic              tid0 = 1'b0;
  logic              rdy0, busy0, done0, own0;
  logic [3:0][15:0]  addrs0;
  logic [3:0]        en0;
  logic [3:0][0:0]   bv0, prop0;

  // DUT 1: MESHUNITS=2, TILEUNITS=2
  logic              start1 = 1'b0;
  logic [15:0]       base1 = '0;
  logic              tid1 = 1'b0;
  logic              rdy1, busy1, done1, own1;
  logic [1:0][15:0]  addrs1;
  logic [1:0]        en1;
  logic [1:0][1:0]   bv1, prop1;

  b_preload_sequencer #(.ADDRWIDTH(16), .MESHUNITS(4), .TILEUNITS(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .b_base_addr(base0),
    .thread_id(tid0), .ready(rdy0), .busy(busy0), .done(done0),
    .load_owner(own0), .B_col_read_addrs(addrs0), .B_col_read_en(en0),
    .b_valid(bv0), .propagate(prop0));

  b_preload_sequencer #(.ADDRWIDTH(16), .MESHUNITS(2), .TILEUNITS(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .b_base_addr(base1),
    .thread_id(tid1), .ready(rdy1), .busy(busy1), .done(done1),
    .load_owner(own1), .B_col_read_addrs(addrs1), .B_col_read_en(en1),
    .b_valid(bv1), .propagate(prop1));

  int n_chk = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per DUT, mk is the number of cycles since the accepting
  // edge (0 = idle). Everything else follows from the cycle-numbering rules.
  int          mesh [2] = '{4, 2};
  int          tile [2] = '{1, 2};
  int          mk   [2] = '{0, 0};
  logic [15:0] mbase[2] = '{16'h0, 16'h0};
  logic        mown [2] = '{1'b0, 1'b0};
  logic        mprop[2] = '{1'b0, 1'b0};

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      int tl;
      logic st;
      logic [15:0] b;
      logic t;
      tl = mesh[d] * tile[d] + mesh[d] - 2;
      st = (d == 0) ? start0 : start1;
      b  = (d == 0) ? base0 : base1;
      t  = (d == 0) ? tid0 : tid1;
      if (reset) begin
        mk[d] = 0; mbase[d] = '0; mown[d] = 1'b0; mprop[d] = 1'b0;
      end else if (mk[d] == 0) begin
        if (st) begin
          mk[d] = 1; mbase[d] = b; mown[d] = t; mprop[d] = ~mprop[d];
        end
      end else if (mk[d] == tl + 3) begin
        mk[d] = 0;
      end else begin
        mk[d] = mk[d] + 1;
      end
    end
  end

  task automatic cmp_dut(input int d, input logic rdy, input logic bsy,
                         input logic dn, input logic own, input logic [63:0] ad,
                         input logic [3:0] en, input logic [7:0] bv,
                         input logic [7:0] pr);
    int k, m, t, n, tl;
    logic [63:0] ead;
    logic [3:0]  een;
    logic [7:0]  ebv, epr;
    k = mk[d]; m = mesh[d]; t = tile[d]; n = m * t; tl = n + m - 2;
    ead = '0; een = '0; ebv = '0; epr = '0;
    for (int i = 0; i < m; i++) begin
      if (k >= 1 + i && k <= n + i) begin
        een[i] = 1'b1;
        ead[i*16 +: 16] = 16'(int'(mbase[d]) + (k - 1 - i) * n + i * t);
      end
      for (int j = 0; j < t; j++) begin
        ebv[i*t + j] = (k >= 2 + i && k <= n + i + 1);
        epr[i*t + j] = mprop[d];
      end
    end
    chk($sformatf("dut%0d ready", d), 64'(rdy), 64'(k == 0));
    chk($sformatf("dut%0d busy", d), 64'(bsy), 64'(k >= 1 && k <= tl + 2));
    chk($sformatf("dut%0d done", d), 64'(dn), 64'(k == tl + 3));
    chk($sformatf("dut%0d load_owner", d), 64'(own), 64'(mown[d]));
    chk($sformatf("dut%0d read_addrs", d), ad, ead);
    chk($sformatf("dut%0d read_en", d), 64'(en), 64'(een));
    chk($sformatf("dut%0d b_valid", d), 64'(bv), 64'(ebv));
    chk($sformatf("dut%0d propagate", d), 64'(pr), 64'(epr));
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      cmp_dut(0, rdy0, busy0, done0, own0, 64'(addrs0), 4'(en0), 8'(bv0), 8'(prop0));
      cmp_dut(1, rdy1, busy1, done1, own1, 64'(addrs1), 4'(en1), 8'(bv1), 8'(prop1));
    end
  end

  task automatic next();
    @(negedge clock);
  endtask

  initial begin
    // Reset, then 10 idle cycles.
    next();
    chk_on = 1'b1;
    next(); next();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next();
      chk("idle ready", 64'(rdy0), 64'd1);
    end
    chk("idle propagate", 64'(prop0), 64'd0);

    // Load base 0x0100 owner 1, second request held from cycle 1.
    start0 = 1'b1; base0 = 16'h0100; tid0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next();
      if (c == 1) begin
        base0 = 16'h0200; tid0 = 1'b0;
        chk("ld1 c1 addr0", 64'(addrs0[0]), 64'h100);
        chk("ld1 owner", 64'(own0), 64'd1);
        chk("ld1 propagate", 64'(prop0), 64'hF);
      end
      if (c == 4) begin
        chk("ld1 c4 addr0", 64'(addrs0[0]), 64'h10C);
        chk("ld1 c4 addr3", 64'(addrs0[3]), 64'h103);
      end
      if (c == 5) chk("ld1 c5 bv3", 64'(bv0[3]), 64'd1);
      if (c == 7) chk("ld1 c7 addr3", 64'(addrs0[3]), 64'h10F);
      if (c == 8) chk("ld1 c8 bv3", 64'(bv0[3]), 64'd1);
      if (c == 9) begin
        chk("ld1 c9 done", 64'(done0), 64'd1);
        chk("ld1 c9 bv3", 64'(bv0[3]), 64'd0);
      end
      if (c == 10) begin
        chk("ld1 c10 ready", 64'(rdy0), 64'd1);
        chk("ld1 c10 done", 64'(done0), 64'd0);
      end
      if (c == 11) begin
        start0 = 1'b0;
        chk("ld2 c11 ready", 64'(rdy0), 64'd0);
        chk("ld2 propagate", 64'(prop0), 64'h0);
        chk("ld2 owner", 64'(own0), 64'd0);
        chk("ld2 addr0", 64'(addrs0[0]), 64'h200);
      end
    end
    for (int c = 0; c < 10; c++) next();
    chk("ld2 finished ready", 64'(rdy0), 64'd1);

    // Address wrap.
    start0 = 1'b1; base0 = 16'hFFFE; tid0 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      next();
      if (c == 1) begin
        start0 = 1'b0;
        chk("wrap c1 addr0", 64'(addrs0[0]), 64'hFFFE);
      end
      if (c == 2) chk("wrap c2 addr0", 64'(addrs0[0]), 64'h0002);
    end

    // Reset asserted in cycle 5 of a load, on both DUTs.
    start0 = 1'b1; base0 = 16'h0300; tid0 = 1'b1;
    start1 = 1'b1; base1 = 16'h0500; tid1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next();
      if (c == 1) begin start0 = 1'b0; start1 = 1'b0; end
      if (c == 5) begin
        chk("rst c5 busy", 64'(busy0), 64'd1);
        reset = 1'b1;
      end
      if (c == 6) begin
        reset = 1'b0;
        chk("rst c6 ready", 64'(rdy0), 64'd1);
        chk("rst c6 en", 64'(en0), 64'd0);
        chk("rst c6 owner", 64'(own0), 64'd0);
        chk("rst c6 propagate", 64'(prop0), 64'd0);
        chk("rst c6 dut1 propagate", 64'(prop1), 64'd0);
      end
    end
    for (int c = 0; c < 10; c++) begin
      next();
      chk("rst no done", 64'(done0), 64'd0);
    end

    // MESHUNITS=2, TILEUNITS=2.
    start1 = 1'b1; base1 = 16'h0040; tid1 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      next();
      if (c == 1) start1 = 1'b0;
      if (c == 2) chk("m2 c2 addr1", 64'(addrs1[1]), 64'h42);
      if (c == 5) chk("m2 c5 addr1", 64'(addrs1[1]), 64'h4E);
      if (c == 3) chk("m2 c3 bv1", 64'(bv1[1]), 64'h3);
      if (c == 6) chk("m2 c6 bv1", 64'(bv1[1]), 64'h3);
      if (c == 7) begin
        chk("m2 c7 bv1", 64'(bv1[1]), 64'h0);
        chk("m2 c7 done", 64'(done1), 64'd1);
      end
      if (c == 8) chk("m2 c8 ready", 64'(rdy1), 64'd1);
    end

    next();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
